// File: rtl/scan_updown_counter_pkg.sv
// Shared constants and helpers for the scan up/down counter.
//   WRAP_MODE / SAT_MODE : values for the WRAP parameter of scan_updown_counter
//   width_ok()           : legal counter width range check (2..32)
package scan_updown_counter_pkg;

  localparam bit WRAP_MODE = 1'b1;
  localparam bit SAT_MODE  = 1'b0;

  function automatic bit width_ok(input int w);
    return (w >= 2) && (w <= 32);
  endfunction

endpackage

// File: rtl/scan_updown_counter_if.sv
// Control/status bundle for scan_updown_counter.
//   master : drives en, up, load, load_val, scan_en, scan_in; observes the rest
//   slave  : the counter; drives count, tc, wrap_evt, scan_out
interface scan_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             scan_en;
  logic             scan_in;
  logic             scan_out;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap_evt;

  modport master (
    output en, up, load, load_val, scan_en, scan_in,
    input  scan_out, count, tc, wrap_evt
  );

  modport slave (
    input  en, up, load, load_val, scan_en, scan_in,
    output scan_out, count, tc, wrap_evt
  );
endinterface

// File: rtl/scan_updown_counter_scan_dff.sv
// Mux-D scan flop with synchronous active-high reset.
//   clk, rst : clock, synchronous reset (q -> 0)
//   scan_en  : 1 selects scan_in, 0 selects functional d
//   scan_in  : serial data from the previous chain stage
//   d        : functional next value
//   q        : registered output
module scan_dff (
  input  logic clk,
  input  logic rst,
  input  logic scan_en,
  input  logic scan_in,
  input  logic d,
  output logic q
);
  logic q_d, q_q;

  always_comb begin
    q_d = scan_en ? scan_in : d;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/scan_updown_counter.sv
// Up/down counter with parallel load, wrap or saturate at the limits, and a
// scan chain through the count bits (scan_in -> bit 0 ... bit WIDTH-1 -> scan_out).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of scan_updown_counter_if
//              count    - register value
//              tc       - en & ~scan_en & (up ? count==max : count==0)
//              wrap_evt - registered pulse, one cycle after a limit hit
//              scan_out - count[WIDTH-1]
// Priority: rst > scan_en > load > en > hold.
module scan_updown_counter
  import scan_updown_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit WRAP  = WRAP_MODE
) (
  input  logic                        clk,
  input  logic                        rst,
  scan_updown_counter_if.slave        bus
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("scan_updown_counter: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] count_d, count_q;
  logic             wrap_evt_d, wrap_evt_q;
  logic             at_max, at_min, tc;

  // Functional next state, limit detection and terminal count. The scan
  // mux lives in each scan_dff, so count_d here is only the non-scan path;
  // wrap_evt_d is still gated by scan_en since that flop is not on the chain.
  always_comb begin
    count_d    = count_q;
    wrap_evt_d = 1'b0;
    at_max     = (count_q == {WIDTH{1'b1}});
    at_min     = (count_q == '0);
    tc         = bus.en & ~bus.scan_en & (bus.up ? at_max : at_min);

    if (bus.scan_en) begin
      count_d = count_q;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_max) begin
          wrap_evt_d = 1'b1;
          count_d    = (WRAP == SAT_MODE) ? count_q : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_min) begin
          wrap_evt_d = 1'b1;
          count_d    = (WRAP == SAT_MODE) ? count_q : {WIDTH{1'b1}};
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // One scan flop per count bit; each bit's serial input is the bit below it.
  scan_dff u_bit [WIDTH-1:0] (
    .clk     (clk),
    .rst     (rst),
    .scan_en (bus.scan_en),
    .scan_in ({count_q[WIDTH-2:0], bus.scan_in}),
    .d       (count_d),
    .q       (count_q)
  );

  always_ff @(posedge clk) begin
    if (rst) wrap_evt_q <= 1'b0;
    else     wrap_evt_q <= wrap_evt_d;
  end

  assign bus.count    = count_q;
  assign bus.tc       = tc;
  assign bus.wrap_evt = wrap_evt_q;
  assign bus.scan_out = count_q[WIDTH-1];

endmodule
